// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: FSM state encoding,
// the fixed fetch opcode and the requester identifiers.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [5:0] OP_LW = 6'b000000;

    localparam logic REQ_IF   = 1'b0;
    localparam logic REQ_DATA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-request round-robin picker. On a tie the requester that did not
// win last time is chosen; the history register is updated by the
// owner of the port when its access completes.
module mem_port_arbiter_rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_if,
    input  logic req_data,
    input  logic update,
    input  logic upd_id,
    output logic winner
);

    logic last_q;
    logic last_d;

    // Record the requester that just finished.
    always_comb begin
        last_d = last_q;
        if (update) begin
            last_d = upd_id;
        end
    end

    // History register; starts as data so fetch wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_DATA;
        end else begin
            last_q <= last_d;
        end
    end

    // Combinational winner selection.
    always_comb begin
        if (req_if && req_data) begin
            winner = ~last_q;
        end else if (req_data) begin
            winner = REQ_DATA;
        end else begin
            winner = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared RAM port sequencer for the fetch and load/store paths.
// Grants one requester, latches its access, holds the RAM strobe until
// MFC and returns read data with a one-cycle done pulse.
// Optional abort of stuck accesses: define MEM_TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              Clk,
    input  logic              RESET_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_grant,
    output logic              if_done,
    input  logic              data_req,
    input  logic [5:0]        data_op,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_grant,
    output logic              data_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_err,
    output logic              RAM_enable,
    output logic [5:0]        RAM_OpCode,
    output logic [ADDR_W-1:0] RAM_addr,
    output logic [DATA_W-1:0] RAM_wdata,
    input  logic [DATA_W-1:0] RAM_rdata,
    input  logic              MFC
);

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("TIMEOUT must be at least 1");
    end

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              en_q, en_d;
    logic [5:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              winner;
    logic              arb_update;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    mem_port_arbiter_rr_arb2 u_arb (
        .clk      (Clk),
        .rst_n    (RESET_n),
        .req_if   (if_req),
        .req_data (data_req),
        .update   (arb_update),
        .upd_id   (owner_q),
        .winner   (winner)
    );

    // Next-state and latched access fields.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        en_d       = en_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        arb_update = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (if_req || data_req) begin
                    owner_d = winner;
                    en_d    = 1'b1;
                    state_d = ST_ISSUE;
                    if (winner == REQ_IF) begin
                        addr_d = if_addr;
                        op_d   = OP_LW;
                    end else begin
                        addr_d  = data_addr;
                        op_d    = data_op;
                        wdata_d = data_wdata;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef MEM_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (MFC) begin
                    rdata_d = RAM_rdata;
                    en_d    = 1'b0;
                    state_d = ST_DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                arb_update = 1'b1;
                state_d    = ST_IDLE;
`ifdef MEM_TIMEOUT_EN
                err_d      = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and access registers; reset drops the strobe immediately.
    always_ff @(posedge Clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= ST_IDLE;
            owner_q <= REQ_IF;
            en_q    <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            en_q    <= en_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // WAIT-cycle counter and abort flag.
    always_ff @(posedge Clk or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign mem_err = (state_q == ST_DONE) && err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign if_grant   = (state_q != ST_IDLE) && (owner_q == REQ_IF);
    assign data_grant = (state_q != ST_IDLE) && (owner_q == REQ_DATA);
    assign if_done    = (state_q == ST_DONE) && (owner_q == REQ_IF);
    assign data_done  = (state_q == ST_DONE) && (owner_q == REQ_DATA);
    assign rdata      = rdata_q;
    assign RAM_enable = en_q;
    assign RAM_OpCode = op_q;
    assign RAM_addr   = addr_q;
    assign RAM_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          Clk;
    logic          RESET_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_grant;
    logic          if_done;
    logic          data_req;
    logic [5:0]    data_op;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_grant;
    logic          data_done;
    logic [DW-1:0] rdata;
    logic          mem_err;
    logic          RAM_enable;
    logic [5:0]    RAM_OpCode;
    logic [AW-1:0] RAM_addr;
    logic [DW-1:0] RAM_wdata;
    logic [DW-1:0] RAM_rdata;
    logic          MFC;

    int checks   = 0;
    int failures = 0;

    // Reference model: who won last (0 fetch, 1 data), last latched
    // write data and last returned read data.
    bit            m_last;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .Clk        (Clk),
        .RESET_n    (RESET_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_grant   (if_grant),
        .if_done    (if_done),
        .data_req   (data_req),
        .data_op    (data_op),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_grant (data_grant),
        .data_done  (data_done),
        .rdata      (rdata),
        .mem_err    (mem_err),
        .RAM_enable (RAM_enable),
        .RAM_OpCode (RAM_OpCode),
        .RAM_addr   (RAM_addr),
        .RAM_wdata  (RAM_wdata),
        .RAM_rdata  (RAM_rdata),
        .MFC        (MFC)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic model_reset();
        m_last  = 1'b1;
        m_wdata = '0;
        m_rdata = '0;
    endtask

    function automatic bit pick(input bit fr, input bit dr);
        if (fr && dr) return !m_last;
        return dr;
    endfunction

    // One complete access starting from IDLE with the requests already set.
    task automatic run_access(input int mfc_delay, input logic [DW-1:0] rd,
                              input bit mfc_issue, input bit nxt_if,
                              input bit nxt_data, output bit win);
        bit ew;
        bit got;
        logic [70:0] exp_bus;
        ew = pick(if_req, data_req);
        win = ew;
        if (ew) exp_bus = {1'b1, data_op, data_addr, data_wdata};
        else    exp_bus = {1'b1, 6'd0, if_addr, m_wdata};
        m_wdata = exp_bus[31:0];
        got = 0;
        for (int n = 0; n < 4; n++) begin
            step();
            if (if_grant || data_grant) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL grant_timeout: no grant within 4 cycles, required one");
        end
        MFC = mfc_issue;
        checks++;
        if ({data_grant, if_grant} !== (ew ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL grant_id: got %b required %b", {data_grant, if_grant}, ew ? 2'b10 : 2'b01);
        end
        checks++;
        if ({RAM_enable, RAM_OpCode, RAM_addr, RAM_wdata} !== exp_bus) begin
            failures++;
            $display("FAIL issue_fields: got %h required %h",
                     {RAM_enable, RAM_OpCode, RAM_addr, RAM_wdata}, exp_bus);
        end
        step();
        for (int d = 0; d < mfc_delay; d++) begin
            MFC = 1'b0;
            checks++;
            if ({RAM_enable, RAM_OpCode, RAM_addr, RAM_wdata} !== exp_bus || if_done || data_done
                || ({data_grant, if_grant} !== (ew ? 2'b10 : 2'b01))) begin
                failures++;
                $display("FAIL wait_hold: got fields %h done %b%b required %h no done",
                         {RAM_enable, RAM_OpCode, RAM_addr, RAM_wdata}, data_done, if_done, exp_bus);
            end
            step();
        end
        MFC = 1'b1;
        RAM_rdata = rd;
        step();
        MFC = 1'($urandom_range(1));
        RAM_rdata = $urandom;
        m_rdata = rd;
        m_last = ew;
        checks++;
        if ({data_done, if_done} !== (ew ? 2'b10 : 2'b01) || mem_err !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: got done %b err %b required %b err 0",
                     {data_done, if_done}, mem_err, ew ? 2'b10 : 2'b01);
        end
        checks++;
        if (rdata !== rd || RAM_enable !== 1'b0 || {data_grant, if_grant} !== (ew ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL done_state: got rdata %h en %b grant %b required rdata %h en 0",
                     rdata, RAM_enable, {data_grant, if_grant}, rd);
        end
        if_req = nxt_if;
        data_req = nxt_data;
        step();
        MFC = 1'b0;
        checks++;
        if ({data_done, if_done, data_grant, if_grant, RAM_enable} !== 5'b0 || rdata !== rd) begin
            failures++;
            $display("FAIL after_done: got done %b%b grant %b%b en %b rdata %h required zeros rdata %h",
                     data_done, if_done, data_grant, if_grant, RAM_enable, rdata, rd);
        end
    endtask

    task automatic test_reset();
        bit got;
        RESET_n = 1'b0;
        if_req = 0; data_req = 0; MFC = 0;
        if_addr = '0; data_op = '0; data_addr = '0; data_wdata = '0; RAM_rdata = '0;
        model_reset();
        step(); step();
        checks++;
        if ({if_grant, if_done, data_grant, data_done, mem_err, RAM_enable, RAM_OpCode,
             RAM_addr, RAM_wdata, rdata} !== '0) begin
            failures++;
            $display("FAIL reset_values: outputs not all zero (en %b op %h addr %h wd %h rd %h)",
                     RAM_enable, RAM_OpCode, RAM_addr, RAM_wdata, rdata);
        end
        RESET_n = 1'b1;
        data_req = 1; data_op = 6'h23; data_addr = 32'h100; data_wdata = 32'h1234_5678;
        got = 0;
        for (int n = 0; n < 4; n++) begin
            step();
            if (data_grant) begin got = 1; break; end
        end
        step(); step();
        checks++;
        if (!got || RAM_enable !== 1'b1) begin
            failures++;
            $display("FAIL reset_setup: got grant %b en %b required 1 1", got, RAM_enable);
        end
        #2 RESET_n = 1'b0;
        #1;
        checks++;
        if ({RAM_enable, if_grant, data_grant, if_done, data_done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_midwait: got en/grants/dones %b required 00000",
                     {RAM_enable, if_grant, data_grant, if_done, data_done});
        end
        data_req = 0;
        step();
        RESET_n = 1'b1;
        step(); step();
        checks++;
        if ({RAM_enable, if_grant, data_grant, if_done, data_done} !== 5'b0 || rdata !== '0) begin
            failures++;
            $display("FAIL reset_idle: got en/grants/dones %b rdata %h required zeros",
                     {RAM_enable, if_grant, data_grant, if_done, data_done}, rdata);
        end
        model_reset();
    endtask

    task automatic test_fetch();
        bit w;
        if_addr = 32'h0000_0010;
        if_req = 1;
        run_access(2, 32'h8210_0003, 1'b0, 1'b0, 1'b0, w);
        checks++;
        if (w !== 1'b0 || rdata !== 32'h8210_0003) begin
            failures++;
            $display("FAIL fetch_only: got winner %b rdata %h required 0 82100003", w, rdata);
        end
    endtask

    task automatic test_store();
        bit w;
        data_op = 6'b000100; data_addr = 32'h40; data_wdata = 32'hDEAD_BEEF;
        data_req = 1;
        run_access(3, 32'h0000_0000, 1'b0, 1'b0, 1'b0, w);
        checks++;
        if (w !== 1'b1 || RAM_wdata !== 32'hDEAD_BEEF || RAM_OpCode !== 6'h04) begin
            failures++;
            $display("FAIL store: got winner %b wd %h op %h required 1 deadbeef 04", w, RAM_wdata, RAM_OpCode);
        end
    endtask

    task automatic test_tie();
        bit w;
        RESET_n = 1'b0;
        step();
        RESET_n = 1'b1;
        model_reset();
        if_addr = 32'h200; data_op = 6'h05; data_addr = 32'h300; data_wdata = 32'hCAFE_0001;
        if_req = 1; data_req = 1;
        for (int k = 0; k < 4; k++) begin
            run_access(1 + k, 32'hA000_0000 + k, 1'b0, 1'b1, k != 3, w);
            checks++;
            if (w !== 1'(k % 2)) begin
                failures++;
                $display("FAIL tie_order: access %0d won by %b required %b", k, w, 1'(k % 2));
            end
        end
        if_req = 0; data_req = 0;
        step(); step(); step(); step(); step();
        checks++;
        if ({if_grant, data_grant, RAM_enable} !== 3'b0) begin
            failures++;
            $display("FAIL tie_drain: got grants %b%b en %b required 000", if_grant, data_grant, RAM_enable);
        end
    endtask

    task automatic test_mfc_ignored();
        bit w;
        MFC = 1;
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if ({RAM_enable, if_grant, data_grant, if_done, data_done} !== 5'b0) begin
                failures++;
                $display("FAIL mfc_idle: got en/grants/dones %b required 00000",
                         {RAM_enable, if_grant, data_grant, if_done, data_done});
            end
        end
        MFC = 0;
        if_addr = 32'h0000_0444;
        if_req = 1;
        run_access(2, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0, w);
    endtask

    task automatic test_random();
        bit w;
        bit fr;
        bit dr;
        for (int it = 0; it < 20; it++) begin
            if (!if_req && !data_req) begin
                case ($urandom_range(2))
                    0: if_req = 1;
                    1: data_req = 1;
                    default: begin if_req = 1; data_req = 1; end
                endcase
            end
            if_addr    = $urandom;
            data_op    = 6'($urandom);
            data_addr  = $urandom;
            data_wdata = $urandom;
            fr = if_req; dr = data_req;
            w = pick(fr, dr);
            // loser keeps its request; winner re-requests at random
            run_access($urandom_range(4), $urandom, 1'($urandom_range(1)),
                       w ? fr : 1'($urandom_range(1)),
                       w ? 1'($urandom_range(1)) : dr, w);
        end
        if_req = 0; data_req = 0;
        step(); step(); step(); step(); step();
    endtask

    task automatic test_timeout();
        bit got;
        data_op = 6'h01; data_addr = 32'h80; data_wdata = 32'h0F0F_0F0F;
        data_req = 1;
        MFC = 0;
        got = 0;
        for (int n = 0; n < 4; n++) begin
            step();
            if (data_grant) begin got = 1; break; end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL timeout_grant: no data grant within 4 cycles");
        end
`ifdef MEM_TIMEOUT_EN
        for (int k = 1; k <= TO; k++) begin
            step();
            checks++;
            if (RAM_enable !== 1'b1 || data_done !== 1'b0) begin
                failures++;
                $display("FAIL timeout_wait: cycle %0d en %b done %b required 1 0", k, RAM_enable, data_done);
            end
        end
        step();
        checks++;
        if ({data_done, mem_err, RAM_enable} !== 3'b110 || rdata !== '0) begin
            failures++;
            $display("FAIL timeout_abort: got done/err/en %b rdata %h required 110 0",
                     {data_done, mem_err, RAM_enable}, rdata);
        end
        data_req = 0;
        step();
        data_req = 1;
        for (int n = 0; n < 4; n++) begin
            step();
            if (data_grant) break;
        end
        for (int k = 1; k <= TO; k++) step();
        MFC = 1; RAM_rdata = 32'h7777_1111;
        step();
        MFC = 0;
        checks++;
        if ({data_done, mem_err} !== 2'b10 || rdata !== 32'h7777_1111) begin
            failures++;
            $display("FAIL timeout_mfc_race: got done/err %b rdata %h required 10 77771111",
                     {data_done, mem_err}, rdata);
        end
        data_req = 0;
        step();
`else
        for (int k = 1; k <= 100; k++) begin
            step();
            checks++;
            if (RAM_enable !== 1'b1 || data_grant !== 1'b1 || data_done !== 1'b0 || mem_err !== 1'b0) begin
                failures++;
                $display("FAIL no_timeout: cycle %0d en %b grant %b done %b err %b required 1 1 0 0",
                         k, RAM_enable, data_grant, data_done, mem_err);
            end
        end
        data_req = 0;
        RESET_n = 1'b0;
        step();
        RESET_n = 1'b1;
        step();
        model_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_tie();
        test_mfc_ignored();
        test_random();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
